// File: rtl/carry_skip_seq_adder_pkg.sv
// carry_skip_seq_adder_pkg: shared slice width, FSM state type and counter-width helper.
// No ports; imported by the interface users and the top level.
package carry_skip_seq_adder_pkg;
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction
endpackage

// File: rtl/carry_skip_seq_adder_if.sv
// carry_skip_seq_adder_if: operand and result valid/ready bundle.
// Ports (signals): in_valid/in_ready/a/b/cin form the operand channel,
// out_valid/out_ready/sum/cout form the result channel.
// master = upstream producer and downstream consumer side, slave = adder side.
interface carry_skip_seq_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/carry_skip_seq_adder_csa.sv
// carry_skip_adder: 4-bit carry-skip adder slice.
// Ports: a_i, b_i (4-bit operands), cin_i (carry in), sum_o (4-bit sum), cout_o (carry out).
module carry_skip_adder
    import carry_skip_seq_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    always_comb begin
        p    = a_i ^ b_i;
        g    = a_i & b_i;
        c    = '0;
        c[0] = cin_i;
        for (int i = 0; i < SLICE_W; i++) c[i+1] = g[i] | (p[i] & c[i]);
        sum_o  = p ^ c[SLICE_W-1:0];
        // When every bit propagates, the carry bypasses the ripple chain.
        cout_o = (&p) ? cin_i : c[SLICE_W];
    end
endmodule

// File: rtl/carry_skip_seq_adder.sv
// carry_skip_seq_adder: multi-cycle WIDTH-bit adder built on one 4-bit carry-skip slice.
// Ports: clk (rising-edge clock), rst_n (async active-low reset),
// bus (slave modport: operand channel in, result channel out).
module carry_skip_seq_adder
    import carry_skip_seq_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    carry_skip_seq_adder_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    if (WIDTH < SLICE_W || WIDTH % SLICE_W != 0) begin : g_bad_width
        $error("carry_skip_seq_adder: WIDTH must be a positive multiple of 4");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SLICE_W-1:0] slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] sum_sh_nxt;

    carry_skip_adder u_slice (
        .a_i    (a_sh_q[SLICE_W-1:0]),
        .b_i    (b_sh_q[SLICE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // New slice result enters at the top; after NSLICE shifts the low nibble lands at bit 0.
    assign sum_sh_nxt = (sum_sh_q >> SLICE_W) | (WIDTH'(slice_sum) << (WIDTH - SLICE_W));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_sh_d  = bus.a;
                b_sh_d  = bus.b;
                carry_d = bus.cin;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_sh_d   = a_sh_q >> SLICE_W;
                b_sh_d   = b_sh_q >> SLICE_W;
                sum_sh_d = sum_sh_nxt;
                carry_d  = slice_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = sum_sh_nxt;
                    cout_d  = slice_cout;
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_carry_skip_seq_adder.sv
// tb_carry_skip_seq_adder: directed and randomized checks of carry_skip_seq_adder against a queue-based reference.
module tb_carry_skip_seq_adder;
    logic clk = 1'b0;
    logic rst_n;
    logic fixed_rdy = 1'b1;
    bit   rand_stall = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n_results = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    carry_skip_seq_adder_if #(.WIDTH(16)) bus ();

    carry_skip_seq_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Sole driver of out_ready, updated shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        bus.out_ready = rand_stall ? ($urandom_range(0, 3) != 0) : fixed_rdy;
    end

    // Every completed result handshake is matched against the oldest expected sum.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("result", {bus.cout, bus.sum}, exp_q.pop_front());
            n_results++;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            n++;
        end while (!acc && n < 100);
        chk("accept", acc, 1);
        if (acc) exp_q.push_back({1'b0, a} + {1'b0, b} + 17'(c));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.cin = 1'($urandom);
    endtask

    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic c, input logic [16:0] want);
        int n;
        send(a, b, c);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 20);
        chk("latency", n, 4);
        chk("sum", bus.sum, want[15:0]);
        chk("cout", bus.cout, want[16]);
        n = 0;
        while (bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("handshake_done", bus.out_valid, 0);
    endtask

    initial begin
        int n, base;
        logic [15:0] s;
        logic co;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_txn(16'h1234, 16'h4321, 1'b0, 17'h05555);
        run_txn(16'hFFFF, 16'h0000, 1'b1, 17'h10000);
        run_txn(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
        run_txn(16'h8000, 16'h8000, 1'b0, 17'h10000);

        // Backpressure with an in_valid pulse while the result is held.
        fixed_rdy = 1'b0;
        send(16'h1111, 16'h2222, 1'b0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 20);
        chk("bp_latency", n, 4);
        s = bus.sum;
        co = bus.cout;
        chk("bp_sum", s, 16'h3333);
        bus.in_valid = 1'b1;
        bus.a = 16'hAAAA;
        bus.b = 16'h5555;
        bus.cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_sum_stable", bus.sum, s);
            chk("bp_cout_stable", bus.cout, co);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
        fixed_rdy = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 10);
        chk("bp_release_cycles", n, 2);
        chk("bp_out_valid_low", bus.out_valid, 0);
        repeat (8) @(negedge clk);
        chk("bp_no_capture", bus.out_valid, 0);

        // Asynchronous reset two cycles into RUN.
        send(16'h5A5A, 16'h1234, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_sum", bus.sum, 0);
        chk("mid_rst_cout", bus.cout, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_txn(16'h0001, 16'h0001, 1'b0, 17'h00002);

        // Randomized stream with random result stalls.
        base = n_results;
        rand_stall = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("random_count", n_results - base, 200);
        rand_stall = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
